sio_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) for the Z80 mini computer's serial port. It runs on the 24 MHz system clock and uses the square-wave `sio_clk` from the SIO clock divider as its oversampling timebase: every transition of `sio_clk` is one sample tick (76.9 k ticks/s ≈ 8 × 9600 baud). Received bytes are presented to the Z80-side bus logic through a one-byte holding register with valid, framing-error and overrun flags.

---
 rtl/sio_rx.sv | 195 +++++++++++++++++++
 tb/tb_sio_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_rx.sv
// sio_rx: 8N1 asynchronous serial receiver, LSB first, oversampled by sio_clk transitions.
// Ports:
//   clk, n_rst   - system clock, asynchronous active-low reset
//   sio_clk      - divider square wave; every transition is one sample tick
//   rxd          - asynchronous serial line, idle high
//   rd           - one-clk read strobe acknowledging the holding register
//   rx_data      - last received byte
//   rx_valid     - holding register full
//   rx_ferr      - stop bit of the byte in rx_data was 0
//   rx_overrun   - sticky: a byte was loaded over an unread one
//   rx_busy      - receiver is inside a frame
module sio_rx #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sio_clk,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned TCNT_W = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] FULL_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [TCNT_W-1:0]   tcnt, tcnt_nx;
    logic [BIT_W-1:0]    bitcnt, bitcnt_nx;
    logic [DATA_W-1:0]   shreg;
    logic                shift_en;
    logic                load;

    logic                sio_clk_d;
    logic                rxd_m;
    logic                rxd_s;
    logic                tick;

    logic [DATA_W-1:0]   rx_data_nx;
    logic                rx_valid_nx;
    logic                rx_ferr_nx;
    logic                rx_overrun_nx;

    // Tick edge detect on the divider output (already in the clk domain)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sio_clk_d <= 1'b0;
        end else begin
            sio_clk_d <= sio_clk;
        end
    end

    assign tick = sio_clk ^ sio_clk_d;

    // Two-flop synchronizer for the serial line; resets to the idle level
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, counter updates and datapath strobes
    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        bitcnt_nx = bitcnt;
        shift_en  = 1'b0;
        load      = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nx = START;
                        tcnt_nx  = '0;
                    end
                end
                START: begin
                    if (tcnt == HALF_LAST) begin
                        // Mid-start-bit check rejects short glitches
                        if (rxd_s) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx  = DATA;
                            tcnt_nx   = '0;
                            bitcnt_nx = '0;
                        end
                    end else begin
                        tcnt_nx = tcnt + TCNT_W'(1);
                    end
                end
                DATA: begin
                    if (tcnt == FULL_LAST) begin
                        shift_en  = 1'b1;
                        tcnt_nx   = '0;
                        bitcnt_nx = bitcnt + BIT_W'(1);
                        if (bitcnt == LAST_BIT) begin
                            state_nx = STOP;
                        end
                    end else begin
                        tcnt_nx = tcnt + TCNT_W'(1);
                    end
                end
                STOP: begin
                    if (tcnt == FULL_LAST) begin
                        load     = 1'b1;
                        tcnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        tcnt_nx = tcnt + TCNT_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Holding register next values; a load in the same cycle as rd takes priority
    always_comb begin
        rx_data_nx    = rx_data;
        rx_valid_nx   = rx_valid;
        rx_ferr_nx    = rx_ferr;
        rx_overrun_nx = rx_overrun;
        if (load) begin
            rx_data_nx    = shreg;
            rx_valid_nx   = 1'b1;
            rx_ferr_nx    = ~rxd_s;
            rx_overrun_nx = rd ? 1'b0 : (rx_overrun | rx_valid);
        end else if (rd) begin
            rx_valid_nx   = 1'b0;
            rx_ferr_nx    = 1'b0;
            rx_overrun_nx = 1'b0;
        end
    end

    // Counters and shift register (LSB arrives first)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            tcnt   <= tcnt_nx;
            bitcnt <= bitcnt_nx;
            if (shift_en) begin
                shreg <= {rxd_s, shreg[DATA_W-1:1]};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_data    <= rx_data_nx;
            rx_valid   <= rx_valid_nx;
            rx_ferr    <= rx_ferr_nx;
            rx_overrun <= rx_overrun_nx;
            rx_busy    <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sio_rx.sv
// tb_sio_rx: self-checking bench for sio_rx with a tick-indexed frame model.
`timescale 1ns/1ps
module tb_sio_rx;

    localparam int OS   = 8;
    localparam int HALF = OS / 2;

    logic       clk;
    logic       n_rst;
    logic       sio_clk;
    logic       rxd;
    logic       rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_overrun;
    logic       rx_busy;

    int n_vec = 0;
    int n_err = 0;

    sio_rx #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sio_clk    (sio_clk),
        .rxd        (rxd),
        .rd         (rd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ferr    (rx_ferr),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sio_clk toggles every 4 clk, so one tick every 4 clk
    initial begin
        int cnt;
        cnt = 0;
        sio_clk = 1'b0;
        forever begin
            @(posedge clk);
            cnt++;
            if (cnt == 4) begin
                cnt = 0;
                #1 sio_clk = ~sio_clk;
            end
        end
    end

    // Behavioural model: frame position is the tick index since the start detection
    event       tick_ev;
    logic       sio_prev = 1'b0;
    bit         m_busy   = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [7:0] m_data   = 8'h00;
    bit         m_valid  = 1'b0;
    bit         m_ferr   = 1'b0;
    bit         m_ovr    = 1'b0;

    initial begin
        bit t;
        bit ld;
        int n;
        forever begin
            @(posedge clk);
            if (!n_rst) begin
                m_busy = 0; m_k = 0; m_byte = 8'h00;
                m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0;
                sio_prev = 1'b0;
            end else begin
                t = (sio_clk !== sio_prev);
                sio_prev = sio_clk;
                ld = 0;
                if (t) begin
                    if (!m_busy) begin
                        if (rxd == 1'b0) begin
                            m_busy = 1;
                            m_k = 0;
                        end
                    end else begin
                        m_k++;
                        if (m_k == HALF) begin
                            if (rxd == 1'b1) m_busy = 0;
                        end else if (m_k > HALF && ((m_k - HALF) % OS) == 0) begin
                            n = (m_k - HALF) / OS - 1;
                            if (n < 8) begin
                                m_byte[n] = rxd;
                            end else begin
                                ld = 1;
                                m_busy = 0;
                            end
                        end
                    end
                end
                if (ld) begin
                    m_ovr   = rd ? 1'b0 : (m_ovr | m_valid);
                    m_data  = m_byte;
                    m_valid = 1;
                    m_ferr  = ~rxd;
                end else if (rd) begin
                    m_valid = 0;
                    m_ferr  = 0;
                    m_ovr   = 0;
                end
                if (t) -> tick_ev;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                chk("rst_data", rx_data, 8'h00);
                chk("rst_flags", {4'b0, rx_valid, rx_ferr, rx_overrun, rx_busy}, 8'h00);
            end else begin
                chk("cyc_data", rx_data, m_data);
                chk("cyc_valid", {7'b0, rx_valid}, {7'b0, m_valid});
                chk("cyc_ferr", {7'b0, rx_ferr}, {7'b0, m_ferr});
                chk("cyc_overrun", {7'b0, rx_overrun}, {7'b0, m_ovr});
                chk("cyc_busy", {7'b0, rx_busy}, {7'b0, m_busy});
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(tick_ev);
            #2;
        end
    endtask

    task automatic pulse_rd();
        @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    // Start bit detected on the next tick; stop bit sampled 76 ticks later
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit rd_at_load);
        rxd = 1'b0;
        ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            ticks(OS);
        end
        rxd = stop_bit;
        ticks(HALF);
        if (rd_at_load) begin
            @(sio_clk);
            rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
            #1;
        end else begin
            ticks(1);
        end
        rxd = 1'b1;
    endtask

    task automatic glitch(input int len);
        rxd = 1'b0;
        ticks(len);
        rxd = 1'b1;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        n_rst = 1'b0;
        rxd   = 1'b1;
        rd    = 1'b0;
        repeat (5) @(posedge clk);
        #1 n_rst = 1'b1;
        chk("reset_valid", {7'b0, rx_valid}, 8'h00);
        chk("reset_data", rx_data, 8'h00);
        ticks(3);

        // Plain byte, then read
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_flags", {5'b0, rx_valid, rx_ferr, rx_overrun}, 8'h04);
        pulse_rd();
        #1;
        chk("a5_rd_valid", {7'b0, rx_valid}, 8'h00);
        chk("a5_rd_data", rx_data, 8'hA5);
        ticks(2);

        // Two-tick glitch: busy, then rejected at the start sample
        rxd = 1'b0;
        ticks(2);
        rxd = 1'b1;
        chk("glitch_busy", {7'b0, rx_busy}, 8'h01);
        ticks(3);
        chk("glitch_idle", {7'b0, rx_busy}, 8'h00);
        chk("glitch_valid", {7'b0, rx_valid}, 8'h00);
        ticks(2);

        // Framing error
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("ferr_data", rx_data, 8'h3C);
        chk("ferr_flags", {5'b0, rx_valid, rx_ferr, rx_overrun}, 8'h06);
        pulse_rd();
        ticks(2);

        // Back-to-back overrun
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_data", rx_data, 8'h22);
        chk("ovr_flags", {5'b0, rx_valid, rx_ferr, rx_overrun}, 8'h05);
        pulse_rd();
        #1;
        chk("ovr_cleared", {5'b0, rx_valid, rx_ferr, rx_overrun}, 8'h00);
        ticks(2);

        // Read coincident with load
        send_frame(8'h55, 1'b1, 1'b0);
        ticks(2);
        send_frame(8'hAA, 1'b1, 1'b1);
        chk("rdload_data", rx_data, 8'hAA);
        chk("rdload_flags", {5'b0, rx_valid, rx_ferr, rx_overrun}, 8'h04);
        ticks(2);

        // Reset during data bit 3
        b = 8'h0F;
        rxd = 1'b0;
        ticks(OS);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            ticks(OS);
        end
        rxd = b[3];
        ticks(HALF);
        chk("pre_rst_busy", {7'b0, rx_busy}, 8'h01);
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_flags", {4'b0, rx_valid, rx_ferr, rx_overrun, rx_busy}, 8'h00);
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b1;
        ticks(3);
        send_frame(8'h0F, 1'b1, 1'b0);
        chk("after_rst_data", rx_data, 8'h0F);
        chk("after_rst_valid", {7'b0, rx_valid}, 8'h01);
        ticks(2);

        // Randomized frames, reads, gaps and glitches
        for (int it = 0; it < 16; it++) begin
            b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) pulse_rd();
            if ($urandom_range(0, 4) == 0) begin
                glitch(int'($urandom_range(1, 3)));
                ticks(6);
            end
            ticks(int'($urandom_range(0, 3)));
        end
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
